// File: rtl/spr_dma.sv
// Sprite DMA initiator: snoops CPU writes to TRIGGER_ADDR, halts the CPU
// and copies a 256-byte page into OAM via repeated writes to TARGET_ADDR.
// Ports: clk_in, rst_in (sync, active-high); cpumc_a_in/cpumc_din_in/
// cpu_r_nw_in snoop the CPU bus; cpumc_dout_in is memory read data;
// cpu_rdy_out halts the CPU; active_out qualifies a_out/d_out/r_nw_out.
// Option: define SPR_DMA_ALIGN_EN for the parity-aligned start cycle.
module spr_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] TARGET_ADDR  = 16'h2004
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] cpumc_a_in,
    input  logic [7:0]  cpumc_din_in,
    input  logic [7:0]  cpumc_dout_in,
    input  logic        cpu_r_nw_in,
    output logic        cpu_rdy_out,
    output logic        active_out,
    output logic [15:0] a_out,
    output logic [7:0]  d_out,
    output logic        r_nw_out
);

`ifdef SPR_DMA_ALIGN_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ALIGN, S_READ, S_WRITE
    } state_t;
    logic q_par;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_WAIT, S_READ, S_WRITE
    } state_t;
`endif

    state_t     q_state, d_state;
    logic [7:0] q_page, d_page;
    logic [7:0] q_idx,  d_idx;
    logic [7:0] q_data, d_data;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            q_state <= S_IDLE;
            q_page  <= 8'h00;
            q_idx   <= 8'h00;
            q_data  <= 8'h00;
        end else begin
            q_state <= d_state;
            q_page  <= d_page;
            q_idx   <= d_idx;
            q_data  <= d_data;
        end
    end

`ifdef SPR_DMA_ALIGN_EN
    // Free-running cycle parity; an odd start costs one extra cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) q_par <= 1'b0;
        else        q_par <= ~q_par;
    end
`endif

    always_comb begin
        d_state = q_state;
        d_page  = q_page;
        d_idx   = q_idx;
        d_data  = q_data;
        unique case (q_state)
            S_IDLE: begin
                if (cpumc_a_in == TRIGGER_ADDR && !cpu_r_nw_in) begin
                    d_page  = cpumc_din_in;
                    d_idx   = 8'h00;
                    d_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // Let an in-flight CPU write cycle finish first.
                if (cpu_r_nw_in) begin
`ifdef SPR_DMA_ALIGN_EN
                    d_state = q_par ? S_ALIGN : S_READ;
`else
                    d_state = S_READ;
`endif
                end
            end
`ifdef SPR_DMA_ALIGN_EN
            S_ALIGN: d_state = S_READ;
`endif
            S_READ: begin
                d_data  = cpumc_dout_in;
                d_state = S_WRITE;
            end
            S_WRITE: begin
                // 8-bit wrap: index never carries into the page.
                d_idx   = q_idx + 8'h01;
                d_state = (q_idx == 8'hFF) ? S_IDLE : S_READ;
            end
            default: d_state = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_rdy_out = 1'b0;
        active_out  = 1'b0;
        a_out       = 16'h0000;
        d_out       = 8'h00;
        r_nw_out    = 1'b1;
        unique case (q_state)
            S_IDLE: cpu_rdy_out = 1'b1;
            S_READ: begin
                active_out = 1'b1;
                a_out      = {q_page, q_idx};
            end
            S_WRITE: begin
                active_out = 1'b1;
                a_out      = TARGET_ADDR;
                d_out      = q_data;
                r_nw_out   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spr_dma.sv
// Directed self-checking bench for spr_dma.
// Memory model returns the low address byte while the DMA owns the bus.
module tb_spr_dma;

    logic        clk_in        = 1'b0;
    logic        rst_in        = 1'b1;
    logic [15:0] cpumc_a_in    = 16'h0000;
    logic [7:0]  cpumc_din_in  = 8'h00;
    logic [7:0]  cpumc_dout_in;
    logic        cpu_r_nw_in   = 1'b1;
    logic        cpu_rdy_out;
    logic        active_out;
    logic [15:0] a_out;
    logic [7:0]  d_out;
    logic        r_nw_out;

    int n_cmp = 0;
    int n_bad = 0;

    spr_dma dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .cpumc_a_in    (cpumc_a_in),
        .cpumc_din_in  (cpumc_din_in),
        .cpumc_dout_in (cpumc_dout_in),
        .cpu_r_nw_in   (cpu_r_nw_in),
        .cpu_rdy_out   (cpu_rdy_out),
        .active_out    (active_out),
        .a_out         (a_out),
        .d_out         (d_out),
        .r_nw_out      (r_nw_out)
    );

    always #5 clk_in = ~clk_in;

    assign cpumc_dout_in = active_out ? a_out[7:0] : 8'h5A;

    // {rdy, active, r_nw, a[15:0], d[7:0]}
    logic [26:0] obs;
    assign obs = {cpu_rdy_out, active_out, r_nw_out, a_out, d_out};

    function automatic logic [26:0] ev_idle();
        return {1'b1, 1'b0, 1'b1, 16'h0000, 8'h00};
    endfunction

    function automatic logic [26:0] ev_halt();
        return {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
    endfunction

    function automatic logic [26:0] ev_read(input logic [7:0] pg,
                                            input logic [7:0] ix);
        return {1'b0, 1'b1, 1'b1, pg, ix, 8'h00};
    endfunction

    function automatic logic [26:0] ev_write(input logic [7:0] dv);
        return {1'b0, 1'b1, 1'b0, 16'h2004, dv};
    endfunction

    // Stimulus only: present a CPU write of pg to $4014 this cycle.
    task automatic fire(input logic [7:0] pg);
        cpumc_a_in   = 16'h4014;
        cpumc_din_in = pg;
        cpu_r_nw_in  = 1'b0;
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_idle()) begin
            n_bad++;
            $display("FAIL reset_state got %h want %h", obs, ev_idle());
        end
        rst_in      = 1'b0;
        cpumc_a_in  = 16'h4015;
        cpu_r_nw_in = 1'b0;
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_idle()) begin
            n_bad++;
            $display("FAIL other_addr_write got %h want %h",
                     obs, ev_idle());
        end
        cpumc_a_in  = 16'h4014;
        cpu_r_nw_in = 1'b1;
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_idle()) begin
            n_bad++;
            $display("FAIL trigger_read got %h want %h", obs, ev_idle());
        end
        cpumc_a_in = 16'h0000;
    endtask

    task automatic test_basic;
        int act;
        act = 0;
        fire(8'h02);
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_halt()) begin
            n_bad++;
            $display("FAIL basic_wait got %h want %h", obs, ev_halt());
        end
        cpumc_a_in   = 16'h0000;
        cpumc_din_in = 8'h00;
        cpu_r_nw_in  = 1'b1;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk_in);
            if (active_out === 1'b1) act++;
            n_cmp++;
            if (obs !== ev_read(8'h02, 8'(k))) begin
                n_bad++;
                $display("FAIL basic_read k=%0d got %h want %h",
                         k, obs, ev_read(8'h02, 8'(k)));
            end
            @(negedge clk_in);
            if (active_out === 1'b1) act++;
            n_cmp++;
            if (obs !== ev_write(8'(k))) begin
                n_bad++;
                $display("FAIL basic_write k=%0d got %h want %h",
                         k, obs, ev_write(8'(k)));
            end
        end
        @(negedge clk_in);
        if (active_out === 1'b1) act++;
        n_cmp++;
        if (obs !== ev_idle()) begin
            n_bad++;
            $display("FAIL basic_done got %h want %h", obs, ev_idle());
        end
        n_cmp++;
        if (act !== 512) begin
            n_bad++;
            $display("FAIL basic_active_cycles got %0d want 512", act);
        end
    endtask

    task automatic test_wait_hold;
        fire(8'h02);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_halt()) begin
                n_bad++;
                $display("FAIL hold_wait i=%0d got %h want %h",
                         i, obs, ev_halt());
            end
            cpumc_a_in   = 16'h0000;
            cpumc_din_in = 8'h00;
            cpu_r_nw_in  = (i == 3);
        end
        for (int k = 0; k < 256; k++) begin
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_read(8'h02, 8'(k))) begin
                n_bad++;
                $display("FAIL hold_read k=%0d got %h want %h",
                         k, obs, ev_read(8'h02, 8'(k)));
            end
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_write(8'(k))) begin
                n_bad++;
                $display("FAIL hold_write k=%0d got %h want %h",
                         k, obs, ev_write(8'(k)));
            end
        end
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_idle()) begin
            n_bad++;
            $display("FAIL hold_done got %h want %h", obs, ev_idle());
        end
    endtask

    task automatic test_page_ff;
        fire(8'hFF);
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_halt()) begin
            n_bad++;
            $display("FAIL ff_wait got %h want %h", obs, ev_halt());
        end
        cpumc_a_in   = 16'h0000;
        cpumc_din_in = 8'h00;
        cpu_r_nw_in  = 1'b1;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_read(8'hFF, 8'(k))) begin
                n_bad++;
                $display("FAIL ff_read k=%0d got %h want %h",
                         k, obs, ev_read(8'hFF, 8'(k)));
            end
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_write(8'(k))) begin
                n_bad++;
                $display("FAIL ff_write k=%0d got %h want %h",
                         k, obs, ev_write(8'(k)));
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_idle()) begin
                n_bad++;
                $display("FAIL ff_after i=%0d got %h want %h",
                         i, obs, ev_idle());
            end
        end
    endtask

    task automatic test_retrigger;
        fire(8'h02);
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_halt()) begin
            n_bad++;
            $display("FAIL retrig_wait got %h want %h", obs, ev_halt());
        end
        cpumc_a_in   = 16'h0000;
        cpumc_din_in = 8'h00;
        cpu_r_nw_in  = 1'b1;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_read(8'h02, 8'(k))) begin
                n_bad++;
                $display("FAIL retrig_read k=%0d got %h want %h",
                         k, obs, ev_read(8'h02, 8'(k)));
            end
            if (k == 8'h40) fire(8'h05);
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_write(8'(k))) begin
                n_bad++;
                $display("FAIL retrig_write k=%0d got %h want %h",
                         k, obs, ev_write(8'(k)));
            end
            cpumc_a_in   = 16'h0000;
            cpumc_din_in = 8'h00;
            cpu_r_nw_in  = 1'b1;
        end
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_idle()) begin
            n_bad++;
            $display("FAIL retrig_done got %h want %h", obs, ev_idle());
        end
    endtask

    task automatic test_reset_mid;
        fire(8'h02);
        @(negedge clk_in);
        cpumc_a_in   = 16'h0000;
        cpumc_din_in = 8'h00;
        cpu_r_nw_in  = 1'b1;
        for (int k = 0; k <= 8'h80; k++) begin
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_read(8'h02, 8'(k))) begin
                n_bad++;
                $display("FAIL rstmid_read k=%0d got %h want %h",
                         k, obs, ev_read(8'h02, 8'(k)));
            end
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_write(8'(k))) begin
                n_bad++;
                $display("FAIL rstmid_write k=%0d got %h want %h",
                         k, obs, ev_write(8'(k)));
            end
        end
        // Reset during WRITE of idx $80, with a coinciding trigger.
        rst_in = 1'b1;
        fire(8'h07);
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_idle()) begin
            n_bad++;
            $display("FAIL rstmid_reset got %h want %h", obs, ev_idle());
        end
        rst_in       = 1'b0;
        cpumc_a_in   = 16'h0000;
        cpumc_din_in = 8'h00;
        cpu_r_nw_in  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_idle()) begin
                n_bad++;
                $display("FAIL rstmid_quiet i=%0d got %h want %h",
                         i, obs, ev_idle());
            end
        end
        fire(8'h03);
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_halt()) begin
            n_bad++;
            $display("FAIL restart_wait got %h want %h", obs, ev_halt());
        end
        cpumc_a_in   = 16'h0000;
        cpumc_din_in = 8'h00;
        cpu_r_nw_in  = 1'b1;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_read(8'h03, 8'(k))) begin
                n_bad++;
                $display("FAIL restart_read k=%0d got %h want %h",
                         k, obs, ev_read(8'h03, 8'(k)));
            end
            @(negedge clk_in);
            n_cmp++;
            if (obs !== ev_write(8'(k))) begin
                n_bad++;
                $display("FAIL restart_write k=%0d got %h want %h",
                         k, obs, ev_write(8'(k)));
            end
        end
        @(negedge clk_in);
        n_cmp++;
        if (obs !== ev_idle()) begin
            n_bad++;
            $display("FAIL restart_done got %h want %h", obs, ev_idle());
        end
    endtask

`ifdef SPR_DMA_ALIGN_EN
    // Edge count since reset; its LSB tracks the design's parity bit.
    int ecnt = 0;
    always @(posedge clk_in) begin
        if (rst_in) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic test_align;
        int halt;
        int guard;
        int want;
        logic odd;
        for (int r = 0; r < 2; r++) begin
            odd = (r == 0);
            // Parity seen at the WAIT-exit edge is (ecnt+1) mod 2.
            if ((((ecnt + 1) % 2) == 1) != odd) @(negedge clk_in);
            want  = odd ? 514 : 513;
            halt  = 0;
            guard = 0;
            fire(8'h10);
            do begin
                @(negedge clk_in);
                if (guard == 0) begin
                    cpumc_a_in   = 16'h0000;
                    cpumc_din_in = 8'h00;
                    cpu_r_nw_in  = 1'b1;
                end
                if (cpu_rdy_out === 1'b0) halt++;
                guard++;
            end while (cpu_rdy_out === 1'b0 && guard < 700);
            n_cmp++;
            if (halt !== want) begin
                n_bad++;
                $display("FAIL align_halt odd=%0b got %0d want %0d",
                         odd, halt, want);
            end
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef SPR_DMA_ALIGN_EN
        test_align();
`else
        test_basic();
        test_wait_hold();
        test_page_ff();
        test_retrigger();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spr_dma.md
Name: spr_dma

Overview:
- CPU-side initiator for the PPU register interface.
- Snoops CPU writes to the sprite DMA trigger register ($4014) and halts the CPU via RDY.
- Copies 256 bytes from CPU page {page,00}..{page,FF} into OAM through repeated writes to the PPU OAM data register ($2004).
- Sits between the CPU, the CPU memory map and the PPU register decode. The top level muxes a_out, d_out and r_nw_out onto the CPU bus while active_out is high.

Parameters:
TRIGGER_ADDR, 16'h4014, CPU address whose write starts a transfer; the written byte is the source page
TARGET_ADDR, 16'h2004, CPU address written once per transferred byte (PPU OAM data register)

Ports:
clk_in  input  1  system clock; all state changes on rising edge
rst_in  input  1  reset; synchronous, active-high
cpumc_a_in  input  16  CPU-side address bus (snooped)
cpumc_din_in  input  8  data the CPU is writing (page number source)
cpumc_dout_in  input  8  memory read data; valid combinationally in the same cycle as the address
cpu_r_nw_in  input  1  CPU bus direction: 1 = read, 0 = write
cpu_rdy_out  output  1  CPU ready; 0 halts the CPU
active_out  output  1  1 = DMA owns the bus (a_out, d_out, r_nw_out valid)
a_out  output  16  DMA bus address
d_out  output  8  DMA write data
r_nw_out  output  1  DMA bus direction: 1 = read, 0 = write

Behaviour:
- Reset, and IDLE state: cpu_rdy_out=1, active_out=0, a_out=16'h0000, d_out=8'h00, r_nw_out=1; page, index and data registers cleared.
- Reset asserted in any state forces IDLE on the next edge. A partial transfer is abandoned and not resumed.
- States: IDLE, WAIT, READ, WRITE. Registers: q_page[7:0], q_idx[7:0], q_data[7:0].
- IDLE: if cpumc_a_in==TRIGGER_ADDR and cpu_r_nw_in==0 at an edge, then q_page<=cpumc_din_in, q_idx<=0, and go to WAIT. Otherwise stay.
- WAIT: cpu_rdy_out=0, active_out=0; the CPU still drives the bus. Holds until cpu_r_nw_in==1, so an in-flight CPU write cycle completes first. Then go to READ.
- READ: active_out=1, cpu_rdy_out=0, a_out={q_page,q_idx}, r_nw_out=1. At the edge, q_data<=cpumc_dout_in, then go to WRITE.
- WRITE: active_out=1, cpu_rdy_out=0, a_out=TARGET_ADDR, d_out=q_data, r_nw_out=0. At the edge:
  - if q_idx==8'hFF, go to IDLE (q_idx wraps to 0);
  - else q_idx<=q_idx+1 and go to READ.
- Index arithmetic is 8-bit and never carries into q_page. A page of 8'hFF reads $FF00..$FFFF.
- Latency: trigger edge, then at least 1 WAIT cycle, then exactly 512 active cycles (256 READ/WRITE pairs). cpu_rdy_out returns to 1 the cycle after the last WRITE.
- Trigger writes are ignored in WAIT/READ/WRITE; no retrigger, and q_page is not updated.
- d_out is 8'h00 whenever the state is not WRITE.
- A trigger coinciding with reset is ignored.
- All outputs are registered or decoded from state only, with no combinational path from inputs. The exception is the WAIT-exit decision, which is internal.

Optional Feature:
- Macro: SPR_DMA_ALIGN_EN.
- Defined:
  - A free-running parity bit toggles every clk_in edge; it resets to 0.
  - On leaving WAIT, if parity==1, one extra ALIGN cycle is inserted before READ: active_out=0, cpu_rdy_out=0.
  - Total halt becomes 513 or 514 cycles, depending on trigger alignment.
- Undefined: no parity register and no ALIGN state; the timing is exactly as in Behaviour.

Test Plan:
- After reset: write $4014=8'h02 with cpu_r_nw_in returning to 1 on the next cycle. Expect:
  - READ addresses $0200..$02FF in order, each followed by a write to $2004 carrying the memory byte (memory model data = low address byte);
  - exactly 512 active cycles;
  - cpu_rdy_out=1 afterwards.
- Hold cpu_r_nw_in=0 for 3 cycles after the trigger. Expect WAIT to persist 3 cycles with cpu_rdy_out=0 and active_out=0, then READ of $0200.
- Page 8'hFF. Expect last read address $FFFF, no access to $0000, and return to IDLE with q_idx=0.
- Second write to $4014=8'h05 during the transfer at idx 8'h40. Expect it ignored; remaining reads stay in page $02.
- Assert rst_in during WRITE at idx 8'h80. Expect all outputs at reset values next cycle and no further accesses. A new trigger then restarts from index 0.
- With SPR_DMA_ALIGN_EN, trigger on odd and even parity. Expect total cpu_rdy_out=0 durations of 514 and 513 cycles respectively (WAIT=1 cycle).
